// File: rtl/mmr_upset_injector.sv
// Fault injector for a K-way modular-redundant register: flips one replica bit
// for a programmed number of cycles, then measures how the voter reacts.
module mmr_upset_injector #(
  parameter int K_MMR   = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [K_MMR-1:0] D_i,
  output logic [K_MMR-1:0] D_o,
  input  logic             inject_req_i,
  input  logic [2:0]       target_i,
  input  logic [CNT_W-1:0] hold_i,
  output logic             inject_ack_o,
  input  logic             mismatch_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             detected_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] latency_o,
  output logic [CNT_W-1:0] upset_count_o
);

  generate
    if (!(K_MMR == 3 || K_MMR == 5)) begin : g_bad_k
      $error("mmr_upset_injector: K_MMR must be 3 or 5");
    end
    if (TIMEOUT < 1) begin : g_bad_tmo
      $error("mmr_upset_injector: TIMEOUT must be at least 1");
    end
  endgenerate

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INJECT  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state;
  logic [2:0]       target_q;
  logic [CNT_W-1:0] inj_left;
  logic [TW-1:0]    tmo_cnt;
  logic             req_ok;
  logic             det_now;
  logic             tmo_hit;
  logic             tracking;

  assign req_ok   = inject_req_i && (32'(target_i) < 32'(K_MMR));
  // A mismatch in the last INJECT cycle already counts as detected for the exit choice.
  assign det_now  = detected_o | mismatch_i;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign tracking = (state == S_INJECT || state == S_WAIT) && !detected_o;

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);

  // Mask decodes straight from state, so an async reset drops it immediately.
  genvar gi;
  generate
    for (gi = 0; gi < K_MMR; gi++) begin : g_lane
      assign D_o[gi] = D_i[gi] ^ ((state == S_INJECT) && (target_q == 3'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      target_q      <= '0;
      inj_left      <= '0;
      tmo_cnt       <= '0;
      inject_ack_o  <= 1'b0;
      detected_o    <= 1'b0;
      timeout_o     <= 1'b0;
      latency_o     <= '0;
      upset_count_o <= '0;
    end else begin
      inject_ack_o <= 1'b0;

      if (tracking) begin
        if (mismatch_i)
          detected_o <= 1'b1;
        else if (latency_o != CNT_MAX)
          latency_o <= latency_o + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (req_ok) begin
            state        <= S_INJECT;
            target_q     <= target_i;
            inj_left     <= (hold_i == '0) ? CNT_W'(1) : hold_i;
            inject_ack_o <= 1'b1;
            detected_o   <= 1'b0;
            timeout_o    <= 1'b0;
            latency_o    <= '0;
            if (upset_count_o != CNT_MAX)
              upset_count_o <= upset_count_o + 1'b1;
          end
        end
        S_INJECT: begin
          if (inj_left == CNT_W'(1)) begin
            state   <= det_now ? S_RECOVER : S_WAIT;
            tmo_cnt <= '0;
          end else begin
            inj_left <= inj_left - 1'b1;
          end
        end
        S_WAIT: begin
          if (mismatch_i) begin
            state   <= S_RECOVER;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            state     <= S_DONE;
            timeout_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          if (!mismatch_i) begin
            state <= S_DONE;
          end else if (tmo_hit) begin
            state     <= S_DONE;
            timeout_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmr_upset_injector.md
MMR_UPSET_INJECTOR -- requirements
Module: mmr_upset_injector

Interface
REQ-001 Parameter K_MMR, default 3: replica count; only 3 and 5 are legal, and elaboration SHALL fail otherwise.
REQ-002 Parameter CNT_W, default 8: width of the hold, latency and count fields.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles spent in WAIT_DET and in RECOVER.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- D_i  in  K_MMR  replica data from upstream logic
- D_o  out  K_MMR  replica data to the register under test
- inject_req_i  in  1  injection request, level
- target_i  in  3  replica index to upset
- hold_i  in  CNT_W  cycles the upset is held
- inject_ack_o  out  1  request-accepted pulse
- mismatch_i  in  1  mismatch flag from the register under test
- busy_o  out  1  high whenever the FSM is not in IDLE
- done_o  out  1  one-cycle completion pulse
- detected_o  out  1  mismatch seen during the last run
- timeout_o  out  1  last run timed out
- latency_o  out  CNT_W  cycles from first upset to mismatch
- upset_count_o  out  CNT_W  accepted injections, saturating

Function
REQ-006 FSM states SHALL be IDLE, INJECT, WAIT_DET, RECOVER, DONE.
REQ-007 IDLE accept: on inject_req_i=1 with target_i<K_MMR, the block SHALL register target_i and hold_i, pulse inject_ack_o next cycle, enter INJECT, and increment upset_count_o (saturating at all-ones).
REQ-008 IDLE reject: a request with target_i>=K_MMR SHALL NOT be accepted; no ack is issued and the FSM stays in IDLE.
REQ-009 Masking: D_o SHALL equal D_i XOR mask. In INJECT the mask is one-hot on the registered target; in every other state the mask is zero.
REQ-010 INJECT SHALL last max(hold_i,1) cycles, with the first INJECT cycle coincident with the inject_ack_o pulse.
REQ-011 Run start: at entry to INJECT, detected_o, timeout_o and latency_o SHALL clear to 0.
REQ-012 Latency counter: it SHALL start at 0 on the first INJECT cycle and increment each cycle, saturating. It freezes, with detected_o set, on the first cycle mismatch_i=1 in INJECT or WAIT_DET.
REQ-013 INJECT exit: go to RECOVER if detected_o=1, otherwise to WAIT_DET.
REQ-014 WAIT_DET: mismatch_i=1 SHALL lead to RECOVER. After TIMEOUT cycles without mismatch, set timeout_o and go to DONE.
REQ-015 RECOVER: the first cycle with mismatch_i=0 SHALL lead to DONE. After TIMEOUT cycles, set timeout_o and go to DONE.
REQ-016 DONE: assert done_o for one cycle, then return to IDLE; a request present in the DONE cycle is ignored.
REQ-017 Status hold: detected_o, timeout_o and latency_o SHALL hold their values until the next accepted request.
REQ-018 inject_req_i in any non-IDLE state SHALL be ignored; it is re-evaluated only in IDLE.
REQ-019 busy_o SHALL be high in every state except IDLE.

Reset
REQ-020 While rst=1, the FSM SHALL be in IDLE, the mask zero (D_o=D_i combinationally), and all outputs and counters 0.
REQ-021 Reset mid-run: rst asserted in any state SHALL clear the mask immediately (asynchronously) and abandon the run without a done_o pulse.

Verification
REQ-022 K_MMR=3, D_i=3'b000, req with target=1, hold=2 -> ack next cycle; D_o=3'b010 for exactly 2 cycles, then 3'b000; upset_count_o=1.
REQ-023 Same run, mismatch_i driven high 3 cycles after the first INJECT cycle and low 2 cycles later -> detected_o=1, latency_o=3, timeout_o=0, one done_o pulse.
REQ-024 mismatch_i held at 0 -> done_o occurs 2+16 cycles after the first INJECT cycle; timeout_o=1, detected_o=0.
REQ-025 target_i=3 with K_MMR=3 -> no ack, busy_o=0, D_o=D_i; with K_MMR=5, target_i=4 and D_i=5'b11111 -> D_o=5'b01111.
REQ-026 rst pulsed in the second INJECT cycle -> D_o=D_i within the same cycle, no done_o, all outputs 0; the next request is accepted normally.
REQ-027 hold_i=0 -> exactly 1 INJECT cycle; 260 back-to-back runs -> upset_count_o saturates at 255.
